// File: rtl/misr_compactor.sv
// MISR response compactor.
// Absorbs masked, folded response patterns into a multiple-input signature
// register for a fixed number of patterns, then compares the signature
// against a golden value and holds the verdict until the next session.
module misr_compactor #(
  parameter int             N    = 17,
  parameter int             M    = 16,
  parameter logic [M-1:0]   POLY = 16'h1021,
  parameter logic [M-1:0]   SEED = '0,
  parameter int             CW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] num_pat,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  input  logic [N-1:0]  in_xmask,
  input  logic [M-1:0]  exp_sig,
  output logic          busy,
  output logic          done,
  output logic [M-1:0]  sig,
  output logic          pass
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] npat;
  logic [M-1:0]  fold_word;
  logic [M-1:0]  sig_nxt;
  logic          absorb;
  logic          last_pat;

  // XOR-fold an N-bit pattern onto M bit positions (bit k lands on k mod M).
  function automatic logic [M-1:0] fold(input logic [N-1:0] d);
    logic [M-1:0] f;
    f = '0;
    for (int k = 0; k < N; k++) begin
      f[k % M] = f[k % M] ^ d[k];
    end
    return f;
  endfunction

  // One MISR shift: feedback from the top bit through the POLY taps, plus input.
  function automatic logic [M-1:0] misr_step(input logic [M-1:0] s,
                                             input logic [M-1:0] f);
    logic [M-1:0] n;
    logic         fb;
    fb   = s[M-1];
    n[0] = fb ^ f[0];
    for (int i = 1; i < M; i++) begin
      n[i] = s[i-1] ^ (fb & POLY[i]) ^ f[i];
    end
    return n;
  endfunction

  // Unknown bits are zeroed before folding so they cannot corrupt the signature.
  assign fold_word = fold(in_data & ~in_xmask);
  assign sig_nxt   = misr_step(sig, fold_word);
  assign absorb    = (state == RUN) && in_valid;
  assign last_pat  = absorb && (cnt == (npat - CW'(1)));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_pat == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_pat) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded directly from the state.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Signature, pattern counter and verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig  <= SEED;
      cnt  <= '0;
      pass <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sig  <= SEED;
            cnt  <= '0;
            pass <= 1'b0;
          end
        end
        RUN: begin
          if (absorb) begin
            sig <= sig_nxt;
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          pass <= (sig == exp_sig);
        end
        default: ;
      endcase
    end
  end

  // Pattern count latched when a session is accepted.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && start) begin
      npat <= num_pat;
    end
  end

endmodule

// File: tb/tb_misr_compactor.sv
// Bench for misr_compactor: directed vector table, hand-written corner
// sequences and randomized sessions against an arithmetic signature model.
module tb_misr_compactor;

  localparam int          N      = 17;
  localparam int          M      = 16;
  localparam int          CW     = 16;
  localparam logic [15:0] POLY_V = 16'h1021;
  localparam logic [15:0] SEED_V = 16'h0000;

  logic          clk;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_pat;
  logic          in_valid;
  logic [N-1:0]  in_data;
  logic [N-1:0]  in_xmask;
  logic [M-1:0]  exp_sig;
  logic          busy;
  logic          done;
  logic [M-1:0]  sig;
  logic          pass;

  int checks = 0;
  int errors = 0;

  misr_compactor #(.N(N), .M(M), .POLY(POLY_V), .SEED(SEED_V), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_pat  (num_pat),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_xmask (in_xmask),
    .exp_sig  (exp_sig),
    .busy     (busy),
    .done     (done),
    .sig      (sig),
    .pass     (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                np;
    logic [31:0][16:0] data;
    logic [31:0][16:0] mask;
    logic [15:0]       exp;
    logic [15:0]       want_sig;
    logic              want_pass;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Signature model: the masked pattern is chopped into M-bit words that are
  // XORed together, then the register is multiplied by x modulo the feedback
  // polynomial and the folded word is added.
  function automatic logic [15:0] model_step(input logic [15:0] s,
                                             input logic [16:0] data,
                                             input logic [16:0] mask);
    longint d;
    longint f;
    longint r;
    d = longint'(data & ~mask);
    f = 0;
    while (d != 0) begin
      f = f ^ (d & 64'hFFFF);
      d = d >> M;
    end
    r = (longint'(s) << 1) & 64'hFFFF;
    if (s[15]) r = r ^ longint'(POLY_V);
    r = r ^ f;
    return r[15:0];
  endfunction

  function automatic vec_t mk(input int np, input logic [16:0] d0, input logic [16:0] d1,
                              input logic [16:0] d2, input logic [16:0] m,
                              input logic [15:0] exp, input logic [15:0] ws, input logic wp);
    vec_t v;
    v.np = np;
    v.data = '0;
    v.mask = '0;
    v.data[0] = d0;
    v.data[1] = d1;
    v.data[2] = d2;
    for (int i = 0; i < 32; i++) v.mask[i] = m;
    v.exp = exp;
    v.want_sig = ws;
    v.want_pass = wp;
    return v;
  endfunction

  // Runs one complete session, checking every cycle against the model.
  task automatic run_session(input int np, input logic [31:0][16:0] data,
                             input logic [31:0][16:0] mask, input logic [15:0] exp,
                             input int maxgap, output logic [15:0] fsig, output logic fpass);
    logic [15:0] m;
    int g;
    m = SEED_V;
    start = 1'b1; num_pat = CW'(np); exp_sig = exp;
    tick();
    start = 1'b0;
    check("pass_cleared_on_start", pass, 0);
    check("busy_after_start", busy, longint'(np != 0));
    for (int p = 0; p < np; p++) begin
      g = $urandom_range(0, maxgap);
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0; in_data = N'($urandom); start = 1'b1; num_pat = CW'(1);
        tick();
        start = 1'b0;
        check("sig_hold_gap", sig, m);
        check("busy_gap", busy, 1);
      end
      in_valid = 1'b1; in_data = data[p]; in_xmask = mask[p];
      tick();
      in_valid = 1'b0;
      m = model_step(m, data[p], mask[p]);
      check("sig_step", sig, m);
      if (p < np - 1) check("no_early_done", done, 0);
    end
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 0);
    // start and in_valid during DONE must both be ignored
    start = 1'b1; in_valid = 1'b1; in_data = 17'h1ffff; in_xmask = '0;
    tick();
    start = 1'b0; in_valid = 1'b0;
    check("done_single_cycle", done, 0);
    check("idle_after_done", busy, 0);
    check("sig_final_model", sig, m);
    check("pass_model", pass, longint'(m == exp));
    fsig = sig;
    fpass = pass;
  endtask

  initial begin
    logic [15:0]       fsig;
    logic              fpass;
    logic [15:0]       pred;
    logic [31:0][16:0] rd;
    logic [31:0][16:0] rm;
    int                np;

    rst = 1'b1; start = 1'b0; num_pat = '0; in_valid = 1'b0;
    in_data = '0; in_xmask = '0; exp_sig = '0;
    tick();
    tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sig", sig, SEED_V);
    check("reset_pass", pass, 0);
    rst = 1'b0;
    tick();

    tbl[0] = mk(1, 17'h00001, 17'h0, 17'h0, 17'h0,     16'h0001, 16'h0001, 1'b1);
    tbl[1] = mk(1, 17'h00001, 17'h0, 17'h0, 17'h00001, 16'h0000, 16'h0000, 1'b1);
    tbl[2] = mk(1, 17'h00001, 17'h0, 17'h0, 17'h0,     16'h0000, 16'h0001, 1'b0);
    tbl[3] = mk(2, 17'h00001, 17'h0, 17'h0, 17'h0,     16'h0002, 16'h0002, 1'b1);
    tbl[4] = mk(1, 17'h10001, 17'h0, 17'h0, 17'h0,     16'h0000, 16'h0000, 1'b1);
    tbl[5] = mk(3, 17'h08000, 17'h0, 17'h10001, 17'h0, 16'h2042, 16'h2042, 1'b1);
    tbl[6] = mk(2, 17'h1ffff, 17'h1ffff, 17'h0, 17'h1ffff, 16'h0001, 16'h0000, 1'b0);
    tbl[7] = mk(0, 17'h0, 17'h0, 17'h0, 17'h0,        16'h0000, 16'h0000, 1'b1);

    for (int i = 0; i < 8; i++) begin
      run_session(tbl[i].np, tbl[i].data, tbl[i].mask, tbl[i].exp, (i == 3) ? 3 : 0, fsig, fpass);
      check($sformatf("tbl%0d_sig", i), fsig, tbl[i].want_sig);
      check($sformatf("tbl%0d_pass", i), fpass, tbl[i].want_pass);
      // in_valid in IDLE must not disturb the held signature or verdict
      in_valid = 1'b1; in_data = 17'h0abcd; in_xmask = '0;
      tick();
      tick();
      in_valid = 1'b0;
      check($sformatf("tbl%0d_idle_sig_hold", i), sig, tbl[i].want_sig);
      check($sformatf("tbl%0d_idle_pass_hold", i), pass, tbl[i].want_pass);
    end

    // sig=8000 then a zero pattern exercises the feedback path alone
    start = 1'b1; num_pat = CW'(3); exp_sig = '0;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 17'h08000; in_xmask = '0;
    tick();
    check("seq_sig_8000", sig, 16'h8000);
    in_data = 17'h00000;
    tick();
    check("seq_feedback_1021", sig, 16'h1021);
    in_data = 17'h10001;
    tick();
    in_valid = 1'b0;
    check("seq_fold_cancel", sig, 16'h2042);
    check("seq_done", done, 1);
    tick();

    // reset in IDLE after a passing session clears the verdict and signature
    check("pre_rst_pass", pass, 0);
    run_session(tbl[3].np, tbl[3].data, tbl[3].mask, tbl[3].exp, 0, fsig, fpass);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("idle_rst_pass", pass, 0);
    check("idle_rst_sig", sig, SEED_V);

    // reset after 3 of 5 patterns aborts without a done pulse
    start = 1'b1; num_pat = CW'(5); exp_sig = '0;
    tick();
    start = 1'b0;
    for (int p = 0; p < 3; p++) begin
      in_valid = 1'b1; in_data = 17'h00001 << p; in_xmask = '0;
      tick();
    end
    check("abort_busy_before", busy, 1);
    rst = 1'b1; start = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sig", sig, 16'h0000);
    check("abort_pass", pass, 0);
    tick();
    check("abort_no_done_later", done, 0);
    check("abort_idle", busy, 0);
    run_session(tbl[5].np, tbl[5].data, tbl[5].mask, tbl[5].exp, 1, fsig, fpass);
    check("post_abort_sig", fsig, 16'h2042);
    check("post_abort_pass", fpass, 1);

    // randomized sessions
    for (int s = 0; s < 30; s++) begin
      np = $urandom_range(0, 20);
      pred = SEED_V;
      for (int p = 0; p < 32; p++) begin
        rd[p] = N'($urandom);
        rm[p] = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
        if (p < np) pred = model_step(pred, rd[p], rm[p]);
      end
      run_session(np, rd, rm, ($urandom_range(0, 1) == 1) ? pred : 16'($urandom),
                  2, fsig, fpass);
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/misr_compactor.md
MISR_COMPACTOR -- requirements
Module: misr_compactor

Interface
REQ-001 Parameter N, default 17, compacted input width (16 sum bits plus carry-out).
REQ-002 Parameter M, default 16, signature width; the design SHALL support 2 <= M, and N >= 1.
REQ-003 Parameter POLY, default 16'h1021, MISR feedback taps; POLY[0] SHALL be 1.
REQ-004 Parameter SEED, default 0, signature value loaded on reset and on start.
REQ-005 Parameter CW, default 16, pattern-counter width.
REQ-006 Clock and reset: one clock; reset is synchronous and active-high.
REQ-007 Port list (name, direction, width, meaning):
- clk, in, 1, clock; all state SHALL change on the rising edge only.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, begin a compaction session.
- num_pat, in, CW, number of patterns to compact; sampled with start.
- in_valid, in, 1, in_data is a pattern to absorb this cycle.
- in_data, in, N, response bits.
- in_xmask, in, N, 1 = bit is unknown (X) and SHALL be forced to 0 before compaction.
- exp_sig, in, M, golden signature; sampled in the DONE state.
- busy, out, 1, session in progress (RUN state).
- done, out, 1, one-cycle pulse ending a session.
- sig, out, M, current signature register.
- pass, out, 1, sig equals exp_sig at session end; held until the next start.

Function
REQ-008 FSM states SHALL be IDLE, RUN and DONE.
REQ-009 IDLE with start=1 SHALL load sig=SEED, cnt=0, latch num_pat, and clear pass; the next state SHALL be RUN, or DONE if num_pat==0.
REQ-010 Masked data SHALL be d[k] = in_data[k] & ~in_xmask[k].
REQ-011 Folding SHALL be f[j] = XOR of d[k] over all k with k mod M == j; a position with no contributors SHALL be 0.
REQ-012 The MISR update SHALL be fb = sig[M-1]; next[0] = fb ^ f[0]; next[i] = sig[i-1] ^ (fb & POLY[i]) ^ f[i] for 1 <= i < M.
REQ-013 In RUN, the MISR update and cnt = cnt+1 SHALL occur only on cycles with in_valid=1; otherwise sig and cnt SHALL hold.
REQ-014 In RUN, in_valid=1 with cnt == latched num_pat-1 SHALL absorb that pattern and move to DONE.
REQ-015 In DONE (exactly one cycle), done=1, pass SHALL be registered as (sig==exp_sig) at the exit edge, and the next state SHALL be IDLE.
REQ-016 pass SHALL become valid the cycle after the done pulse and hold until the next accepted start or reset.
REQ-017 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-018 start SHALL be ignored in RUN and DONE.
REQ-019 in_valid SHALL be ignored in IDLE and DONE.
REQ-020 sig SHALL hold its final value in IDLE until the next start.
REQ-021 num_pat = 2^CW-1 SHALL run to completion; cnt SHALL not wrap before the terminal pattern.
REQ-022 Latency: a start accepted at edge t SHALL give busy=1 from t+1; the last pattern absorbed at edge u SHALL give done=1 during [u, u+1).

Reset
REQ-023 rst=1 SHALL force state=IDLE, sig=SEED, cnt=0, busy=0, done=0 and pass=0 at the next edge, overriding start and in_valid.
REQ-024 Reset asserted mid-RUN SHALL abort the session with no done pulse, and the outputs SHALL match REQ-023 one cycle later.

Verification (defaults N=17, M=16, POLY=16'h1021, SEED=0)
REQ-025 The bench SHALL cover: start with num_pat=1, in_data=17'h00001, mask=0, exp_sig=16'h0001 -> sig=16'h0001, a single-cycle done pulse, then pass=1.
REQ-026 The bench SHALL cover: num_pat=2, data 17'h00001 then 17'h00000, idle cycles with in_valid=0 between them -> sig=16'h0002, held through the gaps.
REQ-027 The bench SHALL cover: sig=16'h8000 followed by a zero pattern -> sig=16'h1021 (feedback); in_data=17'h10001 -> f[0]=0 through fold cancellation, so sig is unchanged by input.
REQ-028 The bench SHALL cover: in_data=17'h00001 with in_xmask=17'h00001 and exp_sig=0 -> sig=0, pass=1; the same stimulus with mask=0 -> pass=0.
REQ-029 The bench SHALL cover: start with num_pat=0 -> done on the following cycle, sig=SEED, and no pattern absorbed.
REQ-030 The bench SHALL cover: rst asserted after 3 of 5 patterns -> busy=0, sig=0, no done pulse; a following start runs a fresh session normally.
